// File: rtl/regfile_scanner.sv
// regfile_scanner: debug-side sweeper of the cpu register-file read port.
// Walks registers 0..15 over the request/grant handshake, captures each value
// into a shadow array, presents shadow[sel] and flags registers whose grant
// timed out. Optional memory-write snoop is compiled in when the macro
// REGSCAN_MEMSNOOP_EN is defined; otherwise its outputs are tied to 0.
module regfile_scanner #(
   parameter int unsigned TIMEOUT = 15  // cycles in REQ without grant before skipping (1..255)
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        scan_en,
   input  logic [3:0]  sel,
   input  logic        cpuout_regfile_grant,
   input  logic [15:0] cpuout_regfile_rd,
   input  logic        cpuout_memupdate,
   input  logic [7:0]  cpuout_memaddr,
   input  logic [15:0] cpuout_memdata,
   output logic        cpuin_regfile_request,
   output logic [3:0]  cpuin_regfile_ra,
   output logic [15:0] shadow_rd,
   output logic [15:0] stale_mask,
   output logic        sweep_done,
   output logic [7:0]  sweep_count,
   output logic [7:0]  last_memaddr,
   output logic [15:0] last_memdata,
   output logic [7:0]  memwr_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_next;
   logic [3:0]  idx, idx_next;
   logic [7:0]  wait_cnt, wait_next;
   logic        capture;
   logic        timed_out;
   logic [15:0] shadow [16];

   // Next-state logic: handshake sequencing, timeout detection, index advance.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      idx_next   = idx;
      wait_next  = wait_cnt;
      capture    = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE: begin
            if (scan_en) state_next = REQ;
         end
         REQ: begin
            // Grant takes priority over a timeout landing on the same edge.
            if (cpuout_regfile_grant) begin
               capture = 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
               timed_out = 1'b1;
            end else begin
               wait_next = wait_cnt + 8'd1;
            end
            if (capture || timed_out) begin
               state_next = GAP;
               idx_next   = idx + 4'd1;
               wait_next  = 8'd0;
            end
         end
         GAP: begin
            // One released cycle guarantees the cpu observes request low.
            state_next = scan_en ? REQ : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state, register index and wait counter.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (RST) begin
         state    <= IDLE;
         idx      <= 4'd0;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_next;
         idx      <= idx_next;
         wait_cnt <= wait_next;
      end
   end

   // Registered handshake outputs, stale flags and sweep bookkeeping.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cpuin_regfile_request <= 1'b0;
         cpuin_regfile_ra      <= 4'd0;
         stale_mask            <= 16'd0;
         sweep_done            <= 1'b0;
         sweep_count           <= 8'd0;
      end else begin
         cpuin_regfile_request <= (state_next == REQ);
         cpuin_regfile_ra      <= idx_next;
         if (capture)   stale_mask[idx] <= 1'b0;
         if (timed_out) stale_mask[idx] <= 1'b1;
         sweep_done <= (capture || timed_out) && (idx == 4'd15);
         if ((capture || timed_out) && (idx == 4'd15)) sweep_count <= sweep_count + 8'd1;
      end
   end

   // Shadow array capture on grant.
   always_ff @(posedge CLK) begin
      // NOTE: the shadow array is reset because the display must read 0 after reset, not stale data.
      if (RST) begin
         for (int i = 0; i < 16; i++) shadow[i] <= 16'd0;
      end else if (capture) begin
         shadow[idx] <= cpuout_regfile_rd;
      end
   end

   // Display read port: no bypass, a fresh capture shows up one edge later.
   always_ff @(posedge CLK) begin
      if (RST) shadow_rd <= 16'd0;
      else     shadow_rd <= shadow[sel];
   end

`ifdef REGSCAN_MEMSNOOP_EN
   // Memory-write snoop, independent of the sweep FSM and of scan_en.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_memaddr <= 8'd0;
         last_memdata <= 16'd0;
         memwr_count  <= 8'd0;
      end else if (cpuout_memupdate) begin
         last_memaddr <= cpuout_memaddr;
         last_memdata <= cpuout_memdata;
         memwr_count  <= memwr_count + 8'd1;
      end
   end
`else
   // Snoop not built: outputs held at 0, inputs intentionally unused.
   logic unused_snoop;
   assign unused_snoop = ^{cpuout_memupdate, cpuout_memaddr, cpuout_memdata};
   assign last_memaddr = 8'd0;
   assign last_memdata = 16'd0;
   assign memwr_count  = 8'd0;
`endif

endmodule

// File: tb/tb_regfile_scanner.sv
// Directed self-checking bench for regfile_scanner: sweep, timeout, enable
// drop, select latency, reset mid-transaction and memory snoop.
module tb_regfile_scanner;

   localparam int TIMEOUT = 15;
`ifdef REGSCAN_MEMSNOOP_EN
   localparam bit SNOOP = 1'b1;
`else
   localparam bit SNOOP = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        scan_en;
   logic [3:0]  sel;
   logic        grant;
   logic [15:0] rd;
   logic        memupdate;
   logic [7:0]  memaddr;
   logic [15:0] memdata;
   logic        request;
   logic [3:0]  ra;
   logic [15:0] shadow_rd;
   logic [15:0] stale_mask;
   logic        sweep_done;
   logic [7:0]  sweep_count;
   logic [7:0]  last_memaddr;
   logic [15:0] last_memdata;
   logic [7:0]  memwr_count;

   int n_checks = 0;
   int n_fail   = 0;
   int done_pulses = 0;
   bit          withhold [16];
   logic [15:0] model_data [16];

   regfile_scanner #(.TIMEOUT(TIMEOUT)) dut (
      .CLK                   (CLK),
      .RST                   (RST),
      .scan_en               (scan_en),
      .sel                   (sel),
      .cpuout_regfile_grant  (grant),
      .cpuout_regfile_rd     (rd),
      .cpuout_memupdate      (memupdate),
      .cpuout_memaddr        (memaddr),
      .cpuout_memdata        (memdata),
      .cpuin_regfile_request (request),
      .cpuin_regfile_ra      (ra),
      .shadow_rd             (shadow_rd),
      .stale_mask            (stale_mask),
      .sweep_done            (sweep_done),
      .sweep_count           (sweep_count),
      .last_memaddr          (last_memaddr),
      .last_memdata          (last_memdata),
      .memwr_count           (memwr_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // CPU grant model: grants one cycle after request is first seen, unless withheld.
   initial begin
      int req_cycles;
      req_cycles = 0;
      grant = 1'b0;
      rd    = 16'd0;
      forever begin
         @(negedge CLK);
         if (request === 1'b1) begin
            req_cycles++;
            if (req_cycles > 1 && !withhold[ra]) begin
               grant = 1'b1;
               rd    = model_data[ra];
            end else begin
               grant = 1'b0;
            end
         end else begin
            req_cycles = 0;
            grant      = 1'b0;
         end
      end
   end

   // Sweep-done pulse counter.
   initial begin
      forever begin
         @(negedge CLK);
         if (sweep_done === 1'b1) done_pulses++;
      end
   end

   // Wait (bounded) for the next sweep_done pulse; returns at that negedge.
   task automatic wait_done(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge CLK);
         if (sweep_done === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check(tag, 32'(found), 32'd1);
   endtask

   // Wait (bounded) until a request on register r is visible.
   task automatic wait_req(input logic [3:0] r, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge CLK);
         if (request === 1'b1 && ra == r) begin
            found = 1'b1;
            break;
         end
      end
      check(tag, 32'(found), 32'd1);
   endtask

   initial begin
      int cnt;
      bit found;
      RST       = 1'b1;
      scan_en   = 1'b0;
      sel       = 4'd0;
      memupdate = 1'b0;
      memaddr   = 8'd0;
      memdata   = 16'd0;
      for (int i = 0; i < 16; i++) begin
         withhold[i]   = 1'b0;
         model_data[i] = 16'h1000 + 16'(i);
      end

      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_request", 32'(request), 32'd0);
      check("rst_ra", 32'(ra), 32'd0);
      check("rst_shadow_rd", 32'(shadow_rd), 32'd0);
      check("rst_stale", 32'(stale_mask), 32'd0);
      check("rst_done", 32'(sweep_done), 32'd0);
      check("rst_sweep_count", 32'(sweep_count), 32'd0);
      check("rst_memwr_count", 32'(memwr_count), 32'd0);
      RST = 1'b0;

      // Full sweep
      scan_en = 1'b1;
      wait_done("sweep1_done");
      scan_en = 1'b0;
      check("sweep1_count", 32'(sweep_count), 32'd1);
      check("sweep1_stale", 32'(stale_mask), 32'd0);
      repeat (4) @(negedge CLK);
      check("sweep1_idle", 32'(request), 32'd0);
      check("sweep1_pulses", 32'(done_pulses), 32'd1);
      for (int n = 0; n < 16; n++) begin
         sel = 4'(n);
         @(negedge CLK);
         check($sformatf("shadow_%0d", n), 32'(shadow_rd), 32'h1000 + 32'(n));
      end

      // Timeout and recovery
      withhold[5] = 1'b1;
      scan_en = 1'b1;
      wait_req(4'd5, "to_wait_ra5");
      cnt = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (request === 1'b1 && ra == 4'd5) cnt++;
         else break;
      end
      check("to_req_cycles", 32'(cnt), 32'd15);
      check("to_stale", 32'(stale_mask), 32'h0020);
      check("to_ra_next", 32'(ra), 32'd6);
      withhold[5] = 1'b0;
      wait_done("to_sweep_done");
      check("to_sweep_count", 32'(sweep_count), 32'd2);
      check("to_stale_held", 32'(stale_mask), 32'h0020);
      wait_done("rec_sweep_done");
      scan_en = 1'b0;
      check("rec_sweep_count", 32'(sweep_count), 32'd3);
      check("rec_stale", 32'(stale_mask), 32'h0000);
      repeat (4) @(negedge CLK);

      // Enable drop during REQ on register 3
      withhold[3]   = 1'b1;
      model_data[3] = 16'hA5A3;
      scan_en = 1'b1;
      wait_req(4'd3, "drop_wait_ra3");
      scan_en = 1'b0;
      repeat (3) @(negedge CLK);
      check("drop_req_held", 32'(request), 32'd1);
      withhold[3] = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (request === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      check("drop_released", 32'(found), 32'd1);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (request === 1'b1) cnt++;
      end
      check("drop_no_request", 32'(cnt), 32'd0);
      check("drop_ra", 32'(ra), 32'd4);
      sel = 4'd3;
      @(negedge CLK);
      check("drop_shadow3", 32'(shadow_rd), 32'h0000A5A3);

      // Re-enable, then select latency on register 7
      model_data[7] = 16'hBEEF;
      sel = 4'd7;
      @(negedge CLK);
      scan_en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (request === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("resume_seen", 32'(found), 32'd1);
      check("resume_ra", 32'(ra), 32'd4);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (request === 1'b1 && grant === 1'b1 && ra == 4'd7) begin
            found = 1'b1;
            break;
         end
      end
      check("lat_grant7", 32'(found), 32'd1);
      @(posedge CLK);
      #1;
      check("lat_edge1", 32'(shadow_rd), 32'h00001007);
      @(posedge CLK);
      #1;
      check("lat_edge2", 32'(shadow_rd), 32'h0000BEEF);

      // Reset mid-REQ on register 9
      wait_req(4'd9, "mid_wait_ra9");
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("mid_request", 32'(request), 32'd0);
      check("mid_ra", 32'(ra), 32'd0);
      check("mid_stale", 32'(stale_mask), 32'd0);
      check("mid_sweep_count", 32'(sweep_count), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      scan_en = 1'b0;
      sel = 4'd7;
      @(negedge CLK);
      check("mid_shadow7", 32'(shadow_rd), 32'd0);
      sel = 4'd1;
      @(negedge CLK);
      check("mid_shadow1", 32'(shadow_rd), 32'd0);
      check("mid_idle", 32'(request), 32'd0);

      // Memory snoop (independent of scan_en)
      memupdate = 1'b1;
      memaddr   = 8'h42;
      memdata   = 16'h1234;
      @(negedge CLK);
      memupdate = 1'b0;
      memaddr   = 8'h00;
      memdata   = 16'h0000;
      check("snoop_addr", 32'(last_memaddr), SNOOP ? 32'h42 : 32'h0);
      check("snoop_data", 32'(last_memdata), SNOOP ? 32'h1234 : 32'h0);
      check("snoop_count", 32'(memwr_count), SNOOP ? 32'd1 : 32'd0);
      @(negedge CLK);
      check("snoop_hold_addr", 32'(last_memaddr), SNOOP ? 32'h42 : 32'h0);
      memupdate = 1'b1;
      memaddr   = 8'h99;
      memdata   = 16'hCAFE;
      @(negedge CLK);
      memupdate = 1'b0;
      check("snoop2_addr", 32'(last_memaddr), SNOOP ? 32'h99 : 32'h0);
      check("snoop2_data", 32'(last_memdata), SNOOP ? 32'hCAFE : 32'h0);
      check("snoop2_count", 32'(memwr_count), SNOOP ? 32'd2 : 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_scanner.md
# regfile_scanner

Debug-side consumer of the cpu's register-file read port. It continuously sweeps registers 0–15 over the cpu's request/grant handshake, which works whether the cpu is running, paused or single-stepping. Each value is captured into a shadow array, and the block presents one selected register to the display logic. It also flags registers whose grant timed out and signals sweep completion.

## Interface
- TIMEOUT, 15: cycles spent in REQ without grant before the register is skipped (1–255).
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- scan_en  in  1  enable sweeping.
- sel  in  4  register index presented on shadow_rd.
- cpuout_regfile_grant  in  1  cpu grants the read port; rd valid while high.
- cpuout_regfile_rd  in  16  register data from cpu.
- cpuout_memupdate  in  1  cpu memory-write strobe (snoop only).
- cpuout_memaddr  in  8  memory-write address.
- cpuout_memdata  in  16  memory-write data.
- cpuin_regfile_request  out  1  read request to cpu.
- cpuin_regfile_ra  out  4  register address to cpu.
- shadow_rd  out  16  registered shadow[sel].
- stale_mask  out  16  bit n set when register n's last attempt timed out.
- sweep_done  out  1  one-cycle pulse when index 15 completes.
- sweep_count  out  8  completed sweeps, wraps 255→0.
- last_memaddr  out  8  last snooped write address.
- last_memdata  out  16  last snooped write data.
- memwr_count  out  8  snooped writes, wraps 255→0.

## Operation
- All outputs are registered. On reset:
  - request=0, ra=0, shadow_rd=0, stale_mask=0, sweep_done=0, sweep_count=0, last_* =0, memwr_count=0.
  - Shadow array cleared to 0, idx=0, wait counter=0, state=IDLE.
- FSM states IDLE, REQ, GAP:
  - IDLE: request=0. scan_en=1 → REQ.
  - REQ: request=1, ra=idx; the wait counter increments each cycle.
    - grant=1 sampled: shadow[idx]←rd and stale_mask[idx]←0, then go to GAP.
    - Counter reaches TIMEOUT with no grant: stale_mask[idx]←1, then go to GAP.
    - On either exit: idx←idx+1 (wraps 15→0) and the counter is cleared.
  - GAP: request=0 for exactly one cycle, which guarantees the cpu sees the release. Then REQ if scan_en=1, else IDLE.
- Grant and timeout in the same cycle: grant wins; capture, no stale.
- scan_en dropped during REQ: the current transaction completes by grant or timeout, then GAP, then IDLE. Request is never withdrawn before grant or timeout.
- Sweep completion (idx 15 → 0 by capture or timeout): sweep_done=1 for one cycle and sweep_count increments.
- grant seen outside REQ is ignored.
- shadow_rd←shadow[sel] every cycle. There is no bypass: a capture into register sel appears on shadow_rd one edge after the shadow write.
- RST mid-transaction: request drops at that edge and no capture occurs.

## Timing
- Edge 0 enters REQ; request=1 and ra are valid after edge 0.
- Grant sampled at edge k: shadow written and request=0 after edge k; REQ for the next index is re-entered after edge k+1.
- Minimum 2 cycles per register, so a full sweep takes at least 32 cycles with a zero-wait grant.
- Timeout exit occurs at the TIMEOUT-th edge spent in REQ.
- shadow_rd latency: 1 cycle from sel change; 2 edges from the capturing grant edge.

## Configuration
- REGSCAN_MEMSNOOP_EN defined:
  - On each cycle with cpuout_memupdate=1: last_memaddr←memaddr, last_memdata←memdata, memwr_count+1.
  - This runs independently of the FSM and of scan_en.
- Undefined: snoop logic is not compiled; last_memaddr, last_memdata and memwr_count are held at 0. Ports remain present.

## Test plan
- Full sweep:
  - Stimulus: reset, scan_en=1, grant model asserts grant one cycle after request with rd=0x1000+ra.
  - Required: after one sweep, sel=n gives shadow_rd=0x1000+n for all n; one sweep_done pulse; sweep_count=1; stale_mask=0.
- Timeout and recovery:
  - Stimulus: grant withheld for ra=5 (TIMEOUT=15).
  - Required: exactly 15 cycles of request on ra=5, then stale_mask=0x0020 and ra advances to 6.
  - Next sweep with grant restored: stale_mask=0x0000.
- Enable drop:
  - Stimulus: scan_en dropped while in REQ on ra=3, grant 4 cycles later.
  - Required: reg 3 captured, request=0 thereafter, FSM in IDLE, idx=4. Re-enabling resumes at ra=4.
- Reset mid-operation:
  - Stimulus: RST pulsed mid-REQ on ra=9.
  - Required: next edge request=0, ra=0, stale_mask=0, sweep_count=0; sel=any gives shadow_rd=0 one edge later.
- Select latency:
  - Stimulus: sel=7, grant for ra=7 with rd=0xBEEF.
  - Required: shadow_rd=0xBEEF exactly two edges after the grant edge, not one.
- Memory snoop with REGSCAN_MEMSNOOP_EN:
  - Stimulus: memupdate pulse with addr 0x42, data 0x1234.
  - Required: next edge last_memaddr=0x42, last_memdata=0x1234, memwr_count=1.
  - Without the macro: all three outputs stay 0.
